rv32_decode_stage: RTL

Parametrised RV32 decode stage that replaces the fixed single-register decoder. It accepts fetched instructions over a valid/ready handshake and decodes RV32I, plus optional M and Zicsr. Decoded bundles sit in a two-entry skid buffer, so a stall from execute never costs a fetch bubble. It sits between fetch and execute, supports pipeline flush, and counts retired-to-execute and illegal instructions.

---
 rtl/rv32_decode_stage.sv | 291 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rv32_decode_stage.sv
// ============================================================================
// rv32_decode_stage : RV32I (+M, +Zicsr) decoder with a 2-entry skid buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

module rv32_decode_stage #(
  parameter int PC_WIDTH     = 32,
  parameter int ENABLE_M     = 1,
  parameter int ENABLE_ZICSR = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [31:0]          i_inst,
  input  logic [PC_WIDTH-1:0]  i_pc,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [PC_WIDTH-1:0]  o_pc,
  output logic [4:0]           o_rs1_addr,
  output logic [4:0]           o_rs2_addr,
  output logic [4:0]           o_rd_addr,
  output logic                 o_rs1_used,
  output logic                 o_rs2_used,
  output logic                 o_rd_we,
  output logic [31:0]          o_imm,
  output logic [2:0]           o_funct3,
  output logic [13:0]          o_alu_op,
  output logic [7:0]           o_mdu_op,
  output logic [10:0]          o_opcode,
  output logic                 o_illegal,
  output logic                 o_ecall,
  output logic                 o_ebreak,
  output logic                 o_mret,
  output logic [CNT_WIDTH-1:0] o_cnt_decoded,
  output logic [CNT_WIDTH-1:0] o_cnt_illegal
);

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic                rs1_used;
    logic                rs2_used;
    logic                rd_we;
    logic [31:0]         imm;
    logic [2:0]          funct3;
    logic [13:0]         alu_op;
    logic [7:0]          mdu_op;
    logic [10:0]         opcode;
    logic                illegal;
    logic                ecall;
    logic                ebreak;
    logic                mret;
  } bundle_t;

  bundle_t dec;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        illegal;
  logic        is_mdu;
  logic        rd_write;
  logic        ecall;
  logic        ebreak;
  logic        mret;

  // ---------------------------------------------------------------- decode
  always_comb begin
    dec      = '0;
    illegal  = 1'b0;
    is_mdu   = 1'b0;
    rd_write = 1'b0;
    ecall    = 1'b0;
    ebreak   = 1'b0;
    mret     = 1'b0;
    f3       = i_inst[14:12];
    f7       = i_inst[31:25];

    dec.pc     = i_pc;
    dec.rs1    = i_inst[19:15];
    dec.rs2    = i_inst[24:20];
    dec.rd     = i_inst[11:7];
    dec.funct3 = f3;

    // the full 7-bit match also rejects inst[1:0] != 2'b11
    case (i_inst[6:0])
      OPC_RTYPE:  dec.opcode[0]  = 1'b1;
      OPC_ITYPE:  dec.opcode[1]  = 1'b1;
      OPC_LOAD:   dec.opcode[2]  = 1'b1;
      OPC_STORE:  dec.opcode[3]  = 1'b1;
      OPC_BRANCH: dec.opcode[4]  = 1'b1;
      OPC_JAL:    dec.opcode[5]  = 1'b1;
      OPC_JALR:   dec.opcode[6]  = 1'b1;
      OPC_LUI:    dec.opcode[7]  = 1'b1;
      OPC_AUIPC:  dec.opcode[8]  = 1'b1;
      OPC_SYSTEM: dec.opcode[9]  = 1'b1;
      OPC_FENCE:  dec.opcode[10] = 1'b1;
      default:    illegal        = 1'b1;
    endcase

    if (dec.opcode[0]) begin
      if (f7 == 7'b0000001 && ENABLE_M != 0)                   is_mdu  = 1'b1;
      else if (f7 == 7'b0000000)                               is_mdu  = 1'b0;
      else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) is_mdu = 1'b0;
      else                                                     illegal = 1'b1;
    end

    if (dec.opcode[1]) begin
      if (f3 == 3'b001 && f7 != 7'b0000000) illegal = 1'b1;
      if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000) illegal = 1'b1;
    end

    if (dec.opcode[9]) begin
      if (f3 == 3'b000) begin
        if (i_inst[19:15] != 5'd0 || i_inst[11:7] != 5'd0) illegal = 1'b1;
        else if (i_inst[31:20] == 12'h000)                  ecall   = 1'b1;
        else if (i_inst[31:20] == 12'h001)                  ebreak  = 1'b1;
        else if (i_inst[31:20] == 12'h302)                  mret    = 1'b1;
        else                                                illegal = 1'b1;
      end else if (ENABLE_ZICSR == 0 || f3 == 3'b100) begin
        illegal = 1'b1;
      end
    end

    if (dec.opcode[0] || dec.opcode[1]) begin
      if (is_mdu) begin
        dec.mdu_op[f3] = 1'b1;
      end else begin
        case (f3)
          3'b000:  if (dec.opcode[0] && i_inst[30]) dec.alu_op[1] = 1'b1;
                   else dec.alu_op[0] = 1'b1;
          3'b001:  dec.alu_op[7] = 1'b1;
          3'b010:  dec.alu_op[2] = 1'b1;
          3'b011:  dec.alu_op[3] = 1'b1;
          3'b100:  dec.alu_op[4] = 1'b1;
          3'b101:  if (i_inst[30]) dec.alu_op[9] = 1'b1;
                   else dec.alu_op[8] = 1'b1;
          3'b110:  dec.alu_op[5] = 1'b1;
          default: dec.alu_op[6] = 1'b1;
        endcase
      end
    end else if (dec.opcode[4]) begin
      case (f3)
        3'b000:  dec.alu_op[10] = 1'b1;
        3'b001:  dec.alu_op[11] = 1'b1;
        3'b100:  dec.alu_op[2]  = 1'b1;
        3'b101:  dec.alu_op[12] = 1'b1;
        3'b110:  dec.alu_op[3]  = 1'b1;
        3'b111:  dec.alu_op[13] = 1'b1;
        default: dec.alu_op[0]  = 1'b1;
      endcase
    end else begin
      dec.alu_op[0] = 1'b1;
    end

    case (1'b1)
      dec.opcode[1], dec.opcode[2], dec.opcode[6]:
        dec.imm = {{20{i_inst[31]}}, i_inst[31:20]};
      dec.opcode[3]:
        dec.imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      dec.opcode[4]:
        dec.imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
      dec.opcode[5]:
        dec.imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
      dec.opcode[7], dec.opcode[8]:
        dec.imm = {i_inst[31:12], 12'h000};
      dec.opcode[9], dec.opcode[10]:
        dec.imm = {20'h00000, i_inst[31:20]};
      default:
        dec.imm = 32'h0000_0000;
    endcase

    dec.rs1_used = dec.opcode[0] | dec.opcode[1] | dec.opcode[2] | dec.opcode[3]
                 | dec.opcode[4] | dec.opcode[6]
                 | (dec.opcode[9] & (f3 != 3'b000) & ~f3[2]);
    dec.rs2_used = dec.opcode[0] | dec.opcode[3] | dec.opcode[4];
    rd_write     = dec.opcode[0] | dec.opcode[1] | dec.opcode[2] | dec.opcode[5]
                 | dec.opcode[6] | dec.opcode[7] | dec.opcode[8]
                 | (dec.opcode[9] & (f3 != 3'b000));

    dec.illegal = illegal;
    dec.rd_we   = rd_write & (dec.rd != 5'd0) & ~illegal;
    dec.ecall   = ecall  & ~illegal;
    dec.ebreak  = ebreak & ~illegal;
    dec.mret    = mret   & ~illegal;
  end

  // ---------------------------------------------------------- skid buffer
  logic                 or_valid_q, or_valid_d;
  logic                 sr_valid_q, sr_valid_d;
  bundle_t              or_q, or_d;
  bundle_t              sr_q, sr_d;
  logic [CNT_WIDTH-1:0] cnt_dec_q, cnt_dec_d;
  logic [CNT_WIDTH-1:0] cnt_ill_q, cnt_ill_d;
  logic                 in_fire;
  logic                 out_fire;

  always_comb begin
    in_fire    = i_valid & ~sr_valid_q;
    out_fire   = or_valid_q & i_ready;
    or_valid_d = or_valid_q;
    sr_valid_d = sr_valid_q;
    or_d       = or_q;
    sr_d       = sr_q;
    cnt_dec_d  = cnt_dec_q;
    cnt_ill_d  = cnt_ill_q;

    if (i_flush) begin
      or_valid_d = 1'b0;
      sr_valid_d = 1'b0;
    end else if (!or_valid_q || i_ready) begin
      if (sr_valid_q) begin
        or_d       = sr_q;
        or_valid_d = 1'b1;
        sr_valid_d = 1'b0;
      end else begin
        or_valid_d = in_fire;
        if (in_fire) or_d = dec;
      end
    end else if (in_fire) begin
      sr_d       = dec;
      sr_valid_d = 1'b1;
    end

    // the output handshake is counted even on a flush edge
    if (out_fire) begin
      if (cnt_dec_q != '1) cnt_dec_d = cnt_dec_q + CNT_ONE;
      if (or_q.illegal && cnt_ill_q != '1) cnt_ill_d = cnt_ill_q + CNT_ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      or_valid_q <= 1'b0;
      sr_valid_q <= 1'b0;
      or_q       <= '0;
      sr_q       <= '0;
      cnt_dec_q  <= '0;
      cnt_ill_q  <= '0;
    end else begin
      or_valid_q <= or_valid_d;
      sr_valid_q <= sr_valid_d;
      or_q       <= or_d;
      sr_q       <= sr_d;
      cnt_dec_q  <= cnt_dec_d;
      cnt_ill_q  <= cnt_ill_d;
    end
  end

  assign o_ready       = ~sr_valid_q;
  assign o_valid       = or_valid_q;
  assign o_pc          = or_q.pc;
  assign o_rs1_addr    = or_q.rs1;
  assign o_rs2_addr    = or_q.rs2;
  assign o_rd_addr     = or_q.rd;
  assign o_rs1_used    = or_q.rs1_used;
  assign o_rs2_used    = or_q.rs2_used;
  assign o_rd_we       = or_q.rd_we;
  assign o_imm         = or_q.imm;
  assign o_funct3      = or_q.funct3;
  assign o_alu_op      = or_q.alu_op;
  assign o_mdu_op      = or_q.mdu_op;
  assign o_opcode      = or_q.opcode;
  assign o_illegal     = or_q.illegal;
  assign o_ecall       = or_q.ecall;
  assign o_ebreak      = or_q.ebreak;
  assign o_mret        = or_q.mret;
  assign o_cnt_decoded = cnt_dec_q;
  assign o_cnt_illegal = cnt_ill_q;

endmodule

`default_nettype wire
